// File: rtl/seq_magnitude_comparator.sv
// seq_magnitude_comparator: multi-cycle A-vs-B magnitude compare, DIGIT bits per clock, MSB slice first.
// Latency: NSLICE edges from the accepting edge to done, or fewer when SEQ_CMP_EARLY_EXIT_EN is defined.
// Backpressure: start is ignored while busy=1; result flags are registered and held until the next completion.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             lesser,
  output logic             equal
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] TOP = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, COMPARE, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb;
  logic             sgn;
  logic             decided;
  logic             rec_gt, rec_lt;
  logic [IW-1:0]    idx;

  logic [DIGIT-1:0] sa, sb;
  logic             slice_gt, slice_lt;
  logic             fin_gt, fin_lt;
  logic             last;

  // Pick the current slice; in signed mode the sign bit is flipped so the top slice compares as offset binary
  always_comb begin
    sa = opa[idx*DIGIT +: DIGIT];
    sb = opb[idx*DIGIT +: DIGIT];
    if (sgn && (idx == TOP)) begin
      sa[DIGIT-1] = ~sa[DIGIT-1];
      sb[DIGIT-1] = ~sb[DIGIT-1];
    end
    slice_gt = (sa > sb);
    slice_lt = (sa < sb);
    // Once a higher slice has decided, lower slices cannot change the outcome
    fin_gt   = decided ? rec_gt : slice_gt;
    fin_lt   = decided ? rec_lt : slice_lt;
  end

`ifdef SEQ_CMP_EARLY_EXIT_EN
  // Stop on the first differing slice, or after the last slice if all are equal
  assign last = (idx == '0) || (slice_gt || slice_lt);
`else
  // Fixed latency: always walk every slice
  assign last = (idx == '0);
`endif

  // Control FSM, operand capture, slice walk and registered result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      opa     <= '0;
      opb     <= '0;
      sgn     <= 1'b0;
      decided <= 1'b0;
      rec_gt  <= 1'b0;
      rec_lt  <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      greater <= 1'b0;
      lesser  <= 1'b0;
      equal   <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          done <= 1'b0;
          if (start) begin
            opa     <= a;
            opb     <= b;
            sgn     <= signed_mode;
            idx     <= TOP;
            decided <= 1'b0;
            rec_gt  <= 1'b0;
            rec_lt  <= 1'b0;
            busy    <= 1'b1;
            state   <= COMPARE;
          end else begin
            state <= IDLE;
          end
        end
        COMPARE: begin
          if (!decided && (slice_gt || slice_lt)) begin
            decided <= 1'b1;
            rec_gt  <= slice_gt;
            rec_lt  <= slice_lt;
          end
          if (last) begin
            greater <= fin_gt;
            lesser  <= fin_lt;
            equal   <= !fin_gt && !fin_lt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FINISH;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb_seq_magnitude_comparator: directed vectors against seq_magnitude_comparator (WIDTH=16, DIGIT=4).
// Latency: expected done latency depends on whether SEQ_CMP_EARLY_EXIT_EN is defined.
// Backpressure: exercises ignored starts while busy and back-to-back starts in the FINISH cycle.
module tb_seq_magnitude_comparator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic        greater;
  logic        lesser;
  logic        equal;

  int n_cmp;
  int n_bad;

  // Flags from the previous completion; they must hold during the next compare
  logic pg, pl, pe;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  localparam int LAT_TOP = 1;
`else
  localparam int LAT_TOP = 4;
`endif

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .signed_mode(signed_mode),
    .busy(busy),
    .done(done),
    .greater(greater),
    .lesser(lesser),
    .equal(equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one compare from a non-busy cycle and check latency, handshake and flags
  task automatic do_cmp(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                        input int lat, input logic eg, input logic el, input logic ee,
                        input string nm);
    int cnt;
    a = av; b = bv; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_accept: busy=%b done=%b, required busy=1 done=0", nm, busy, done);
    end
    n_cmp++;
    if ({greater, lesser, equal} !== {pg, pl, pe}) begin
      n_bad++;
      $display("FAIL %s_hold: flags gle=%b%b%b, required %b%b%b", nm, greater, lesser, equal, pg, pl, pe);
    end
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++;
    if (cnt !== lat) begin
      n_bad++;
      $display("FAIL %s_latency: done after %0d edges, required %0d", nm, cnt, lat);
    end
    n_cmp++;
    if ({greater, lesser, equal, busy} !== {eg, el, ee, 1'b0}) begin
      n_bad++;
      $display("FAIL %s_result: gle=%b%b%b busy=%b, required gle=%b%b%b busy=0",
               nm, greater, lesser, equal, busy, eg, el, ee);
    end
    pg = eg; pl = el; pe = ee;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    pg = 1'b0; pl = 1'b0; pe = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, greater, lesser, equal} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: bdgle=%b, required 00000", i,
                 {busy, done, greater, lesser, equal});
      end
    end
    // Complete a compare, then hit reset mid-cycle while done/greater are high
    do_cmp(16'h9000, 16'h1000, 1'b0, LAT_TOP, 1'b1, 1'b0, 1'b0, "pre_async");
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, greater, lesser, equal} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_async: bdgle=%b before next edge, required 00000",
               {busy, done, greater, lesser, equal});
    end
    #2 rst = 1'b0;
    pg = 1'b0; pl = 1'b0; pe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    do_cmp(16'h1234, 16'h1235, 1'b0, 4, 1'b0, 1'b1, 1'b0, "u_lt_low_slice");
    do_cmp(16'h7777, 16'h7777, 1'b0, 4, 1'b0, 1'b0, 1'b1, "u_equal");
    do_cmp(16'h9000, 16'h1000, 1'b0, LAT_TOP, 1'b1, 1'b0, 1'b0, "u_gt_top_slice");
  endtask

  task automatic test_signed();
    do_cmp(16'h9000, 16'h1000, 1'b1, LAT_TOP, 1'b0, 1'b1, 1'b0, "s_neg_vs_pos");
    do_cmp(16'hFFFF, 16'h8000, 1'b1, LAT_TOP, 1'b1, 1'b0, 1'b0, "s_m1_vs_min");
    do_cmp(16'h0000, 16'hFFFF, 1'b1, LAT_TOP, 1'b1, 1'b0, 1'b0, "s_zero_vs_m1");
  endtask

  task automatic test_back_to_back();
    int cnt;
    // Make sure we start from IDLE with a distinguishable previous result
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    // Second request while busy must be ignored
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL hs_busy: busy=%b, required 1", busy);
    end
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_cmp++;
    if (cnt !== 4) begin
      n_bad++;
      $display("FAIL hs_latency: done after %0d edges, required 4", cnt);
    end
    n_cmp++;
    if ({greater, lesser, equal} !== 3'b010) begin
      n_bad++;
      $display("FAIL hs_ignored_start: gle=%b%b%b, required 010", greater, lesser, equal);
    end
    pg = 1'b0; pl = 1'b1; pe = 1'b0;
    // Start issued in the FINISH cycle is accepted immediately
    do_cmp(16'h9000, 16'h1000, 1'b0, LAT_TOP, 1'b1, 1'b0, 1'b0, "b2b_finish_start");
    do_cmp(16'h4321, 16'h4321, 1'b1, 4, 1'b0, 1'b0, 1'b1, "b2b_equal");
  endtask

  task automatic test_reset_mid_op();
    a = 16'h0005; b = 16'h0003; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, greater, lesser, equal} !== 5'b0) begin
      n_bad++;
      $display("FAIL midop_reset: bdgle=%b, required 00000", {busy, done, greater, lesser, equal});
    end
    rst = 1'b0;
    pg = 1'b0; pl = 1'b0; pe = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL midop_no_done cycle %0d: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    do_cmp(16'h0005, 16'h0003, 1'b0, 4, 1'b1, 1'b0, 1'b0, "after_reset_gt");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
